// File: rtl/key_debouncer_array.sv
// rtl/key_debouncer_array.sv - multi-channel key debouncer with press/release pulses and long-hold flag
// Each channel: synchroniser, run-length stability counter, optional hold counter.
module key_debouncer_array #(
  parameter int CHANNELS     = 8,
  parameter int STABLE_COUNT = 4,
  parameter int HOLD_COUNT   = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sample_en,
  input  logic [CHANNELS-1:0] i_raw_in,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_held,
  output logic                o_any_level
);

  localparam int   CNT_W  = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam int   HCNT_W = (HOLD_COUNT > 0) ? $clog2(HOLD_COUNT + 1) : 1;
  localparam logic INACT  = (ACTIVE_LOW != 0);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_lvl;
    logic                   r_prs;
    logic                   r_rel;
    logic                   w_s;
    logic                   w_last;

    assign w_s    = r_sync[SYNC_STAGES-1] ^ INACT;
    assign w_last = (r_cnt == CNT_W'(STABLE_COUNT - 1));

    // Synchroniser free-runs so the sample strobe only gates the decision logic.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {SYNC_STAGES{INACT}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw_in[g]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
        r_prs <= 1'b0;
        r_rel <= 1'b0;
      end else begin
        r_prs <= 1'b0;
        r_rel <= 1'b0;
        if (i_sample_en) begin
          if (w_s == r_lvl) begin
            r_cnt <= '0;
          end else if (w_last) begin
            r_lvl <= w_s;
            r_cnt <= '0;
            r_prs <= w_s;
            r_rel <= ~w_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign o_level[g]   = r_lvl;
    assign o_press[g]   = r_prs;
    assign o_release[g] = r_rel;

    if (HOLD_COUNT > 0) begin : g_hold
      logic [HCNT_W-1:0] r_hcnt;
      logic              r_hld;
      logic              w_fall;

      // Clear on the same edge the release pulse is generated.
      assign w_fall = i_sample_en && r_lvl && !w_s && w_last;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hcnt <= '0;
          r_hld  <= 1'b0;
        end else if (!r_lvl || w_fall) begin
          r_hcnt <= '0;
          r_hld  <= 1'b0;
        end else if (i_sample_en && (r_hcnt < HCNT_W'(HOLD_COUNT))) begin
          r_hcnt <= r_hcnt + 1'b1;
          if (r_hcnt == HCNT_W'(HOLD_COUNT - 1)) begin
            r_hld <= 1'b1;
          end
        end
      end

      assign o_held[g] = r_hld;
    end else begin : g_nohold
      assign o_held[g] = 1'b0;
    end
  end

  assign o_any_level = |o_level;

endmodule

// File: tb/tb_key_debouncer_array.sv
// tb/tb_key_debouncer_array.sv - bench for key_debouncer_array
// Two instances: defaults (every-clk sampling) and 16-ch active-low with hold and sparse strobe.
module tb_key_debouncer_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        se0, se1;
  logic [7:0]  raw0;
  logic [15:0] raw1;
  logic [7:0]  level0, press0, rel0, held0;
  logic        any0, any1;
  logic [15:0] level1, press1, rel1, held1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debouncer_array dut0 (
    .clk(clk), .rst_n(rst_n), .i_sample_en(se0), .i_raw_in(raw0),
    .o_level(level0), .o_press(press0), .o_release(rel0), .o_held(held0),
    .o_any_level(any0)
  );

  key_debouncer_array #(
    .CHANNELS(16), .STABLE_COUNT(4), .HOLD_COUNT(10), .SYNC_STAGES(2), .ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .i_sample_en(se1), .i_raw_in(raw1),
    .o_level(level1), .o_press(press1), .o_release(rel1), .o_held(held1),
    .o_any_level(any1)
  );

  function automatic logic [15:0] obs(int sel);
    case (sel)
      0: obs = {8'h00, level0};
      1: obs = {8'h00, press0};
      2: obs = {8'h00, rel0};
      3: obs = {15'h0, any0};
      4: obs = {8'h00, held0};
      5: obs = level1;
      6: obs = press1;
      7: obs = rel1;
      8: obs = held1;
      9: obs = {15'h0, any1};
      default: obs = 16'hdead;
    endcase
  endfunction

  task automatic check(string tag, logic [15:0] o, logic [15:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic expect_at(int d, string tag, int sel, logic [15:0] e);
    exp_t x;
    x.due = cyc + d;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: pop every expectation that has come due and compare
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        check(sbq[i].tag, obs(sbq[i].sel), sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  // Sparse strobe for dut1: enabled on edges that are multiples of 4
  initial begin
    se1 = 1'b0;
    forever begin
      @(negedge clk);
      se1 = (cyc % 4 == 3);
    end
  end

  initial begin
    rst_n = 1'b0;
    se0   = 1'b1;
    raw0  = 8'h00;
    raw1  = 16'hffff;
    tick(1);
    expect_at(1, "rst_level0", 0, 16'h0);
    expect_at(1, "rst_press0", 1, 16'h0);
    expect_at(1, "rst_any0",   3, 16'h0);
    expect_at(1, "rst_level1", 5, 16'h0);
    expect_at(1, "rst_held1",  8, 16'h0);
    expect_at(1, "rst_any1",   9, 16'h0);
    tick(2);
    rst_n = 1'b1;
    expect_at(6,  "al_idle_press",   6, 16'h0);
    expect_at(10, "al_idle_level",   5, 16'h0);
    expect_at(10, "al_idle_release", 7, 16'h0);
    tick(3);

    // Basic press on ch0
    raw0[0] = 1'b1;
    expect_at(5, "p0_level_early", 0, 16'h0000);
    expect_at(5, "p0_press_early", 1, 16'h0000);
    expect_at(6, "p0_level",       0, 16'h0001);
    expect_at(6, "p0_press",       1, 16'h0001);
    expect_at(6, "p0_any",         3, 16'h0001);
    expect_at(7, "p0_press_off",   1, 16'h0000);
    expect_at(7, "p0_level_hold",  0, 16'h0001);
    tick(10);

    // Three-sample glitch on ch3 must not register
    raw0[3] = 1'b1;
    tick(3);
    raw0[3] = 1'b0;
    expect_at(4, "gl_press_a", 1, 16'h0000);
    expect_at(8, "gl_press_b", 1, 16'h0000);
    expect_at(8, "gl_level",   0, 16'h0001);
    tick(8);

    // Bounce then stable: one press, only after the final full run
    raw0[3] = 1'b1;
    tick(3);
    raw0[3] = 1'b0;
    tick(1);
    raw0[3] = 1'b1;
    expect_at(2, "bn_press_mid",  1, 16'h0000);
    expect_at(5, "bn_press_pre",  1, 16'h0000);
    expect_at(5, "bn_level_pre",  0, 16'h0001);
    expect_at(6, "bn_press",      1, 16'h0008);
    expect_at(6, "bn_level",      0, 16'h0009);
    expect_at(7, "bn_press_off",  1, 16'h0000);
    tick(10);

    // Press then release ch2
    raw0[2] = 1'b1;
    tick(10);
    raw0[2] = 1'b0;
    expect_at(5, "rl_rel_pre",   2, 16'h0000);
    expect_at(5, "rl_level_pre", 0, 16'h000d);
    expect_at(6, "rl_rel",       2, 16'h0004);
    expect_at(6, "rl_level",     0, 16'h0009);
    expect_at(6, "rl_no_press",  1, 16'h0000);
    expect_at(6, "rl_held0_off", 4, 16'h0000);
    expect_at(7, "rl_rel_off",   2, 16'h0000);
    tick(10);

    // dut1: active-low pin 15 pressed with strobe every 4th clk
    while (cyc % 4 != 0) tick(1);
    raw1[15] = 1'b0;
    expect_at(15, "al_level_pre",  5, 16'h0000);
    expect_at(16, "al_level",      5, 16'h8000);
    expect_at(16, "al_press",      6, 16'h8000);
    expect_at(16, "al_any",        9, 16'h0001);
    expect_at(17, "al_press_off",  6, 16'h0000);
    expect_at(55, "al_held_pre",   8, 16'h0000);
    expect_at(56, "al_held",       8, 16'h8000);
    tick(60);
    while (cyc % 4 != 0) tick(1);
    raw1[15] = 1'b1;
    expect_at(15, "al_held_stay",  8, 16'h8000);
    expect_at(15, "al_rel_pre",    7, 16'h0000);
    expect_at(16, "al_rel",        7, 16'h8000);
    expect_at(16, "al_held_clr",   8, 16'h0000);
    expect_at(16, "al_level_clr",  5, 16'h0000);
    expect_at(16, "al_rel_nopress", 6, 16'h0000);
    expect_at(17, "al_rel_off",    7, 16'h0000);
    tick(20);

    // Reset in the middle of a press run on ch5
    raw0[5] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("mr_level_async", {8'h00, level0}, 16'h0000);
    check("mr_any_async",   {15'h0, any0},   16'h0000);
    check("mr_press_async", {8'h00, press0}, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    expect_at(1, "mr_level_after",  0, 16'h0000);
    expect_at(5, "mr_level_pre",    0, 16'h0000);
    expect_at(5, "mr_press_pre",    1, 16'h0000);
    expect_at(6, "mr_press",        1, 16'h0029);
    expect_at(6, "mr_level",        0, 16'h0029);
    expect_at(6, "mr_any",          3, 16'h0001);
    expect_at(6, "mr_dut1_level",   5, 16'h0000);
    expect_at(6, "mr_dut1_press",   6, 16'h0000);
    expect_at(7, "mr_press_off",    1, 16'h0000);
    tick(10);

    check("sb_drained", 16'(sbq.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
